// File: rtl/bit_serial_alu_seq.sv
// bit_serial_alu_seq: drives an external 1-bit ALU slice LSB-first to build a WIDTH-bit result plus flags.
module bit_serial_alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             overflow,
    output logic             zero,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic [3:0]       slice_ctrl,
    input  logic             slice_res,
    input  logic             slice_cout
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr, word_nx;
    logic [3:0] op_r;
    logic [CW-1:0] cnt;
    logic carry, legal, arith, last, accept;
    assign legal = op <= 4'd4;
    assign arith = op_r[3:1] == 3'd0;
    assign last = cnt == CW'(WIDTH - 1);
    assign accept = state == IDLE && start;
    assign word_nx = {slice_res, result[WIDTH-1:1]};
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        busy = state == RUN;
        done = state == DONE;
        slice_a = 1'b0;
        slice_b = 1'b0;
        slice_cin = 1'b0;
        slice_ctrl = 4'd0;
        if (accept) state_nx = legal ? RUN : DONE;
        else if (state == RUN && last) state_nx = DONE;
        else if (state == DONE) state_nx = IDLE;
        if (state == RUN) begin
            slice_a = a_sr[0];
            slice_b = (op_r == 4'd1) ? ~b_sr[0] : b_sr[0];
            slice_cin = carry;
            slice_ctrl = arith ? 4'd0 : op_r;
        end
    end
    // Operands shift right so the slice always sees bit 0; result fills from the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr <= '0;
            b_sr <= '0;
            op_r <= 4'd0;
            cnt <= '0;
            carry <= 1'b0;
            result <= '0;
            c_out <= 1'b0;
            overflow <= 1'b0;
            zero <= 1'b0;
        end else if (accept) begin
            a_sr <= a_in;
            b_sr <= b_in;
            op_r <= op;
            cnt <= '0;
            carry <= op == 4'd1;
            result <= '0;
            c_out <= 1'b0;
            overflow <= 1'b0;
            zero <= !legal;
        end else if (state == RUN) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            cnt <= cnt + CW'(1);
            result <= word_nx;
            carry <= arith & slice_cout;
            if (last) begin
                c_out <= arith & slice_cout;
                overflow <= arith & (carry ^ slice_cout);
                zero <= word_nx == '0;
            end
        end
    end
endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// tb_bit_serial_alu_seq: directed vectors with a scoreboard queue checked whenever done pulses.
module tb_bit_serial_alu_seq;
    logic clk = 1'b0;
    logic rst, start, busy, done, c_out, overflow, zero;
    logic slice_a, slice_b, slice_cin, slice_res, slice_cout;
    logic [3:0] op, slice_ctrl;
    logic [7:0] a_in, b_in, result;
    logic [1:0] s_sum;
    int checks = 0;
    int errors = 0;
    typedef struct packed {
        logic [7:0] r;
        logic c, v, z;
    } exp_t;
    exp_t q[$];
    exp_t e;

    always #5 clk = ~clk;

    bit_serial_alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .result(result), .c_out(c_out), .overflow(overflow),
        .zero(zero), .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
        .slice_ctrl(slice_ctrl), .slice_res(slice_res), .slice_cout(slice_cout)
    );

    // Behavioural 1-bit ALU slice the sequencer is paired with
    always_comb begin
        s_sum = {1'b0, slice_a} + {1'b0, slice_b} + {1'b0, slice_cin};
        slice_res = (slice_ctrl == 4'd0) ? s_sum[0] :
                    (slice_ctrl == 4'd2) ? (slice_a & slice_b) :
                    (slice_ctrl == 4'd3) ? (slice_a | slice_b) :
                    (slice_ctrl == 4'd4) ? (slice_a ^ slice_b) : 1'b0;
        slice_cout = (slice_ctrl == 4'd0) & s_sum[1];
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", n, act, exp);
        end
    endtask

    always @(negedge clk)
        if (done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done got result %0h expected no done", result);
            end else begin
                e = q.pop_front();
                chk("result", result, e.r);
                chk("c_out", c_out, e.c);
                chk("overflow", overflow, e.v);
                chk("zero", zero, e.z);
            end
        end

    task automatic issue(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] r, input logic c, input logic v, input logic z,
                         input int lat, input int nbusy, input bit glitch);
        int n, nb;
        bit got;
        @(negedge clk);
        op = o;
        a_in = a;
        b_in = b;
        start = 1'b1;
        q.push_back('{r: r, c: c, v: v, z: z});
        n = 0;
        nb = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            start = glitch && i == 2;
            if (glitch) begin
                op = 4'd1;
                a_in = 8'hEE;
                b_in = 8'h77;
            end
            n++;
            if (done) got = 1;
            else if (busy) nb++;
        end
        chk("latency", got ? n : 0, lat);
        chk("busy_cycles", nb, nbusy);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        op = 4'd0;
        a_in = 8'h00;
        b_in = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, done, result, c_out, overflow, zero, slice_a, slice_b, slice_cin, slice_ctrl}, 0);
        rst = 1'b0;
        issue(4'd0, 8'h0F, 8'h01, 8'h10, 0, 0, 0, 9, 8, 0);
        issue(4'd0, 8'hFF, 8'h01, 8'h00, 1, 0, 1, 9, 8, 0);
        issue(4'd0, 8'h7F, 8'h01, 8'h80, 0, 1, 0, 9, 8, 0);
        issue(4'd1, 8'h05, 8'h07, 8'hFE, 0, 0, 0, 9, 8, 0);
        issue(4'd1, 8'h80, 8'h01, 8'h7F, 1, 1, 0, 9, 8, 0);
        issue(4'd2, 8'hA5, 8'h3C, 8'h24, 0, 0, 0, 9, 8, 0);
        issue(4'd3, 8'hA5, 8'h3C, 8'hBD, 0, 0, 0, 9, 8, 0);
        issue(4'd4, 8'hA5, 8'h3C, 8'h99, 0, 0, 0, 9, 8, 0);
        issue(4'hF, 8'hA5, 8'h3C, 8'h00, 0, 0, 1, 1, 0, 0);
        issue(4'd0, 8'h12, 8'h34, 8'h46, 0, 0, 0, 9, 8, 1);
        @(negedge clk);
        op = 4'd0;
        a_in = 8'h11;
        b_in = 8'h22;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_mid_run", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_run_reset_outputs", {busy, done, result, c_out, overflow, zero, slice_a, slice_b, slice_cin, slice_ctrl}, 0);
        repeat (12) @(negedge clk);
        issue(4'd0, 8'h03, 8'h04, 8'h07, 0, 0, 0, 9, 8, 0);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
